ex_stage_muldiv: RTL

- Execute stage that consumes the ID/EX pipeline register outputs and feeds the EX/MEM register.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages, selects the ALU B operand (register or sign-extended immediate) and the destination register (Rt or Rd), and performs single-cycle ALU operations.
- Contains an iterative multiply/divide unit with HI/LO registers. While that unit is busy, a dependent instruction asserts stall back to the IF/ID/ID_EX registers.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/ex_stage_muldiv_if.sv | 56 +++++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 rtl/ex_stage_muldiv.sv | 100 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the execute stage: ALU opcodes, funct
//                codes, mult/div FSM states and forwarding selects.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT_ADD   = 6'h20;
   localparam logic [5:0] FUNCT_SUB   = 6'h22;
   localparam logic [5:0] FUNCT_AND   = 6'h24;
   localparam logic [5:0] FUNCT_OR    = 6'h25;
   localparam logic [5:0] FUNCT_SLT   = 6'h2A;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   // True for the four functs that launch the iterative unit.
   function automatic logic is_md_funct(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

   // True for functs that touch HI/LO and therefore must wait for the unit.
   function automatic logic is_hilo_funct(input logic [5:0] f);
      return is_md_funct(f) || (f == FUNCT_MFHI) || (f == FUNCT_MFLO);
   endfunction

   // EX/MEM beats MEM/WB; register 0 is hard-wired and never forwarded.
   function automatic fwd_sel_t fwd_select(input logic [4:0] idx,
                                           input logic       exm_we,
                                           input logic [4:0] exm_rd,
                                           input logic       mwb_we,
                                           input logic [4:0] mwb_rd);
      if (exm_we && (exm_rd != 5'd0) && (exm_rd == idx))
         return FWD_EXMEM;
      else if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == idx))
         return FWD_MEMWB;
      else
         return FWD_REG;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_muldiv_if
//  Description : Bundle of ID/EX inputs, forwarding sources and EX/MEM
//                outputs of the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_muldiv_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic            reg_write_in;
   logic [1:0]      alu_op_in;
   logic [5:0]      funct_in;
   logic            alu_src_in;
   logic            reg_dst_in;
   logic [XLEN-1:0] read_data_1_in;
   logic [XLEN-1:0] read_data_2_in;
   logic [XLEN-1:0] sign_extend_in;
   logic [4:0]      rs_in;
   logic [4:0]      rt_in;
   logic [4:0]      rd_in;
   logic            ex_mem_reg_write;
   logic [4:0]      ex_mem_rd;
   logic [XLEN-1:0] ex_mem_result;
   logic            mem_wb_reg_write;
   logic [4:0]      mem_wb_rd;
   logic [XLEN-1:0] mem_wb_data;
   logic [XLEN-1:0] alu_result_out;
   logic [XLEN-1:0] store_data_out;
   logic [4:0]      write_reg_out;
   logic            zero_out;
   logic            reg_write_out;
   logic            valid_out;
   logic            stall_out;
   logic            md_busy_out;

   modport slave (
      input  valid_in, reg_write_in, alu_op_in, funct_in, alu_src_in,
             reg_dst_in, read_data_1_in, read_data_2_in, sign_extend_in,
             rs_in, rt_in, rd_in, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
             mem_wb_reg_write, mem_wb_rd, mem_wb_data,
      output alu_result_out, store_data_out, write_reg_out, zero_out,
             reg_write_out, valid_out, stall_out, md_busy_out
   );

   modport master (
      output valid_in, reg_write_in, alu_op_in, funct_in, alu_src_in,
             reg_dst_in, read_data_1_in, read_data_2_in, sign_extend_in,
             rs_in, rt_in, rd_in, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
             mem_wb_reg_write, mem_wb_rd, mem_wb_data,
      input  alu_result_out, store_data_out, write_reg_out, zero_out,
             reg_write_out, valid_out, stall_out, md_busy_out
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative shift-add multiplier / restoring divider with
//                HI/LO result registers. Signed ops run on magnitudes and the
//                sign is applied in the DONE cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MD_STEPS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_start,
   input  logic [5:0]      i_funct,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo,
   output logic            o_busy
);

   // Bits retired per RUN edge, so that MD_STEPS edges always cover XLEN bits.
   localparam int              BPS      = (XLEN + MD_STEPS - 1) / MD_STEPS;
   localparam int              CNT_W    = (MD_STEPS > 1) ? $clog2(MD_STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MD_STEPS - 1);

   md_state_t         r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [2*XLEN-1:0] r_acc;      // mult: {partial, multiplier}; div: {rem, quot}
   logic [XLEN-1:0]   r_opnd;     // multiplicand or divisor magnitude
   logic              r_is_div;
   logic              r_neg_lo;
   logic              r_neg_hi;
   logic [XLEN-1:0]   r_hi, r_lo;

   logic              w_signed, w_div, w_a_neg, w_b_neg, w_div0;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic [2*XLEN-1:0] w_cap_acc;
   logic [XLEN-1:0]   w_cap_opnd;
   logic              w_cap_neg_lo, w_cap_neg_hi;
   logic [2*XLEN-1:0] w_acc_step;
   logic [XLEN+1:0]   w_trial;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_fix_hi, w_fix_lo;

   // Operand capture: magnitudes plus result signs; divide-by-zero keeps the raw dividend.
   always_comb begin
      w_signed     = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_DIV);
      w_div        = (i_funct == FUNCT_DIV)  || (i_funct == FUNCT_DIVU);
      w_a_neg      = w_signed && i_op_a[XLEN-1];
      w_b_neg      = w_signed && i_op_b[XLEN-1];
      w_a_mag      = w_a_neg ? (~i_op_a + 1'b1) : i_op_a;
      w_b_mag      = w_b_neg ? (~i_op_b + 1'b1) : i_op_b;
      w_div0       = w_div && (i_op_b == '0);
      w_cap_acc    = '0;
      w_cap_opnd   = '0;
      w_cap_neg_lo = 1'b0;
      w_cap_neg_hi = 1'b0;
      if (w_div0) begin
         // Divisor 0 makes every trial subtract succeed: quot = all ones, rem = dividend.
         w_cap_acc  = {{XLEN{1'b0}}, i_op_a};
      end else if (w_div) begin
         w_cap_acc    = {{XLEN{1'b0}}, w_a_mag};
         w_cap_opnd   = w_b_mag;
         w_cap_neg_lo = w_a_neg ^ w_b_neg;
         w_cap_neg_hi = w_a_neg;
      end else begin
         w_cap_acc    = {{XLEN{1'b0}}, w_b_mag};
         w_cap_opnd   = w_a_mag;
         w_cap_neg_lo = w_a_neg ^ w_b_neg;
         w_cap_neg_hi = w_a_neg ^ w_b_neg;
      end
   end

   // One RUN edge worth of shift-add or restoring-subtract iterations.
   always_comb begin
      w_acc_step = r_acc;
      w_trial    = '0;
      w_sum      = '0;
      for (int k = 0; k < BPS; k++) begin
         if ((int'(r_cnt) * BPS + k) < XLEN) begin
            if (r_is_div) begin
               w_trial = {1'b0, w_acc_step[2*XLEN-1:XLEN-1]} - {2'b00, r_opnd};
               if (!w_trial[XLEN+1])
                  w_acc_step = {w_trial[XLEN-1:0], w_acc_step[XLEN-2:0], 1'b1};
               else
                  w_acc_step = {w_acc_step[2*XLEN-2:0], 1'b0};
            end else begin
               w_sum = {1'b0, w_acc_step[2*XLEN-1:XLEN]} +
                       (w_acc_step[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
               w_acc_step = {w_sum, w_acc_step[XLEN-1:1]};
            end
         end
      end
   end

   // Sign fix applied when leaving DONE.
   always_comb begin
      w_prod   = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
      w_fix_hi = w_prod[2*XLEN-1:XLEN];
      w_fix_lo = w_prod[XLEN-1:0];
      if (r_is_div) begin
         w_fix_lo = r_neg_lo ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
         w_fix_hi = r_neg_hi ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= MD_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next-state: IDLE -> RUN on start, RUN -> DONE on the last step, DONE -> IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         MD_IDLE: if (i_start) w_state_next = MD_RUN;
         MD_RUN:  if (r_cnt == LAST_CNT) w_state_next = MD_DONE;
         MD_DONE: w_state_next = MD_IDLE;
         default: w_state_next = MD_IDLE;
      endcase
   end

   // Datapath registers: capture, iterate, then commit HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (i_start) begin
                  r_cnt    <= '0;
                  r_acc    <= w_cap_acc;
                  r_opnd   <= w_cap_opnd;
                  r_is_div <= w_div;
                  r_neg_lo <= w_cap_neg_lo;
                  r_neg_hi <= w_cap_neg_hi;
               end
            end
            MD_RUN: begin
               r_acc <= w_acc_step;
               r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
            end
            MD_DONE: begin
               r_hi <= w_fix_hi;
               r_lo <= w_fix_lo;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_busy = (r_state == MD_RUN) || (r_state == MD_DONE);

endmodule
`default_nettype wire

// File: rtl/ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_muldiv
//  Description : Execute stage: operand forwarding, B/destination select,
//                single-cycle ALU and hazard stall for the mult/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_muldiv
   import mips_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MD_STEPS = 32
) (
   input  logic             clk,
   input  logic             reset,
   ex_stage_muldiv_if.slave bus
);

   fwd_sel_t        w_fwd_a, w_fwd_b;
   logic [XLEN-1:0] w_rs_val, w_rt_val, w_alu_b, w_alu_res;
   logic [XLEN-1:0] w_hi, w_lo;
   logic            w_busy, w_stall, w_md_op, w_md_start;

   assign w_fwd_a = fwd_select(bus.rs_in, bus.ex_mem_reg_write, bus.ex_mem_rd,
                               bus.mem_wb_reg_write, bus.mem_wb_rd);
   assign w_fwd_b = fwd_select(bus.rt_in, bus.ex_mem_reg_write, bus.ex_mem_rd,
                               bus.mem_wb_reg_write, bus.mem_wb_rd);

   // Forwarding muxes for Rs and Rt.
   always_comb begin
      w_rs_val = bus.read_data_1_in;
      w_rt_val = bus.read_data_2_in;
      case (w_fwd_a)
         FWD_EXMEM: w_rs_val = bus.ex_mem_result;
         FWD_MEMWB: w_rs_val = bus.mem_wb_data;
         default:   w_rs_val = bus.read_data_1_in;
      endcase
      case (w_fwd_b)
         FWD_EXMEM: w_rt_val = bus.ex_mem_result;
         FWD_MEMWB: w_rt_val = bus.mem_wb_data;
         default:   w_rt_val = bus.read_data_2_in;
      endcase
   end

   assign w_alu_b = bus.alu_src_in ? bus.sign_extend_in : w_rt_val;

   // ALU; undefined encodings produce zero.
   always_comb begin
      w_alu_res = '0;
      case (bus.alu_op_in)
         ALU_OP_ADD: w_alu_res = w_rs_val + w_alu_b;
         ALU_OP_SUB: w_alu_res = w_rs_val - w_alu_b;
         ALU_OP_FUNCT: begin
            case (bus.funct_in)
               FUNCT_ADD:  w_alu_res = w_rs_val + w_alu_b;
               FUNCT_SUB:  w_alu_res = w_rs_val - w_alu_b;
               FUNCT_AND:  w_alu_res = w_rs_val & w_alu_b;
               FUNCT_OR:   w_alu_res = w_rs_val | w_alu_b;
               FUNCT_SLT:  w_alu_res = {{(XLEN-1){1'b0}},
                                        ($signed(w_rs_val) < $signed(w_alu_b))};
               FUNCT_MFHI: w_alu_res = w_hi;
               FUNCT_MFLO: w_alu_res = w_lo;
               default:    w_alu_res = '0;
            endcase
         end
         default: w_alu_res = '0;
      endcase
   end

   // Hazard: any HI/LO user waits while the unit iterates; never during reset.
   assign w_md_op    = is_md_funct(bus.funct_in);
   assign w_stall    = bus.valid_in && w_busy && is_hilo_funct(bus.funct_in) && !reset;
   assign w_md_start = bus.valid_in && !w_stall && w_md_op;

   muldiv_unit #(
      .XLEN     (XLEN),
      .MD_STEPS (MD_STEPS)
   ) u_muldiv (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_md_start),
      .i_funct (bus.funct_in),
      .i_op_a  (w_rs_val),
      .i_op_b  (w_rt_val),
      .o_hi    (w_hi),
      .o_lo    (w_lo),
      .o_busy  (w_busy)
   );

   assign bus.alu_result_out = w_alu_res;
   assign bus.store_data_out = w_rt_val;
   assign bus.write_reg_out  = bus.reg_dst_in ? bus.rd_in : bus.rt_in;
   assign bus.zero_out       = (w_alu_res == '0);
   assign bus.valid_out      = bus.valid_in && !w_stall;
   assign bus.reg_write_out  = bus.reg_write_in && bus.valid_in && !w_stall && !w_md_op;
   assign bus.stall_out      = w_stall;
   assign bus.md_busy_out    = w_busy;

endmodule
`default_nettype wire
